led_pwm_dimmer: RTL and testbench

Downstream stage of the LED pattern generator. It consumes the 15-bit LED drive vector and produces brightness-controlled PWM outputs for the front-panel LEDs. Each channel can optionally fade in and out. Control and status are mapped as an OPB register slave on the same bus as the other test-firmware peripherals.

---
 rtl/led_pwm_dimmer.sv | 187 ++++++++++++++++++
 tb/tb_led_pwm_dimmer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_dimmer.sv
// PWM brightness stage for the front-panel LEDs: synchronised on/off requests,
// optional per-channel fading, OPB register slave for control and status.
module led_pwm_dimmer #(
  parameter int NCH       = 15,
  parameter int PWM_BITS  = 8,
  parameter int PRE_WIDTH = 16
) (
  input  logic           OPB_CLK,
  input  logic           OPB_RST_N,
  input  logic [31:0]    OPB_DI,
  output logic [31:0]    OPB_DO,
  input  logic [2:0]     OPB_ADDR,
  input  logic           OPB_RE,
  input  logic           OPB_WE,
  input  logic [NCH-1:0] LED_IN,
  output logic [NCH-1:0] LED_OUT
);

  localparam logic [2:0] A_CNTRL    = 3'd0;
  localparam logic [2:0] A_PRESCALE = 3'd1;
  localparam logic [2:0] A_DUTY     = 3'd2;
  localparam logic [2:0] A_STEP     = 3'd3;
  localparam logic [2:0] A_STATUS   = 3'd4;
  localparam logic [2:0] A_CHSEL    = 3'd5;
  localparam logic [2:0] A_LEVEL    = 3'd6;

  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((1 << PWM_BITS) - 2);

  logic                 en;
  logic                 fade_en;
  logic                 invert;
  logic [PRE_WIDTH-1:0] prescale;
  logic [PWM_BITS-1:0]  duty;
  logic [PWM_BITS-1:0]  step;
  logic [3:0]           chsel;

  logic [NCH-1:0]       led_meta_p0;
  logic [NCH-1:0]       led_sync_p1;
  logic [NCH-1:0]       led_out_p1;

  logic [PRE_WIDTH-1:0] pre_cnt;
  logic [PWM_BITS-1:0]  pwm_cnt;
  logic                 tick;
  logic                 period;
  logic                 prescale_wr;

  logic [PWM_BITS-1:0]  level  [NCH];
  logic [PWM_BITS-1:0]  target [NCH];
  logic [NCH-1:0]       on;
  logic                 busy;
  logic [PWM_BITS-1:0]  level_sel;
  logic [31:0]          rd_data;
  logic                 rd_hit;
  logic                 unused_di;

  assign unused_di = ^OPB_DI[31:PRE_WIDTH];

  // Moves lvl toward tgt by stp; the extra headroom bits keep the sum and
  // difference from wrapping so the result clamps exactly at tgt.
  function automatic logic [PWM_BITS-1:0] fade_step(
    input logic [PWM_BITS-1:0] lvl,
    input logic [PWM_BITS-1:0] tgt,
    input logic [PWM_BITS-1:0] stp
  );
    logic signed [PWM_BITS+1:0] lvl_s;
    logic signed [PWM_BITS+1:0] tgt_s;
    logic signed [PWM_BITS+1:0] stp_s;
    logic signed [PWM_BITS+1:0] nxt_s;
    lvl_s = $signed({2'b00, lvl});
    tgt_s = $signed({2'b00, tgt});
    stp_s = $signed({2'b00, stp});
    if (lvl_s < tgt_s) begin
      nxt_s = lvl_s + stp_s;
      if (nxt_s > tgt_s) nxt_s = tgt_s;
    end else begin
      nxt_s = lvl_s - stp_s;
      if (nxt_s < tgt_s) nxt_s = tgt_s;
    end
    return nxt_s[PWM_BITS-1:0];
  endfunction

  assign prescale_wr = OPB_WE && (OPB_ADDR == A_PRESCALE);

  always_ff @(posedge OPB_CLK) begin
    if (!OPB_RST_N) begin
      en       <= 1'b1;
      fade_en  <= 1'b0;
      invert   <= 1'b0;
      prescale <= PRE_WIDTH'(124);
      duty     <= PWM_BITS'(8'h80);
      step     <= PWM_BITS'(8'h08);
      chsel    <= 4'd0;
    end else if (OPB_WE) begin
      case (OPB_ADDR)
        A_CNTRL: begin
          en      <= OPB_DI[0];
          fade_en <= OPB_DI[1];
          invert  <= OPB_DI[2];
        end
        A_PRESCALE: prescale <= OPB_DI[PRE_WIDTH-1:0];
        A_DUTY:     duty     <= OPB_DI[PWM_BITS-1:0];
        A_STEP:     step     <= OPB_DI[PWM_BITS-1:0];
        A_CHSEL:    chsel    <= OPB_DI[3:0];
        default: ;
      endcase
    end
  end

  // Stage p0/p1: two-flop synchroniser for the slow pattern-generator inputs
  always_ff @(posedge OPB_CLK) begin
    if (!OPB_RST_N) begin
      led_meta_p0 <= '0;
      led_sync_p1 <= '0;
    end else begin
      led_meta_p0 <= LED_IN;
      led_sync_p1 <= led_meta_p0;
    end
  end

  assign tick   = en && (pre_cnt == prescale);
  assign period = tick && (pwm_cnt == PWM_LAST);

  always_ff @(posedge OPB_CLK) begin
    if (!OPB_RST_N || !en) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      if (prescale_wr || tick) pre_cnt <= '0;
      else                     pre_cnt <= pre_cnt + 1'b1;
      if (tick) pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      target[i] = led_sync_p1[i] ? duty : '0;
      on[i]     = level[i] > pwm_cnt;
      busy      = busy | (level[i] != target[i]);
    end
  end

  // Levels only change on the period strobe so a PWM period never glitches.
  always_ff @(posedge OPB_CLK) begin
    for (int i = 0; i < NCH; i++) begin
      if (!OPB_RST_N || !en)  level[i] <= '0;
      else if (period)        level[i] <= fade_en ? fade_step(level[i], target[i], step)
                                                  : target[i];
    end
  end

  // Stage p1: registered LED drive
  always_ff @(posedge OPB_CLK) begin
    if (!OPB_RST_N) led_out_p1 <= '0;
    else            led_out_p1 <= (on & {NCH{en}}) ^ {NCH{invert}};
  end

  assign LED_OUT = led_out_p1;

  always_comb begin
    level_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (chsel == 4'(i)) level_sel = level[i];
    end
  end

  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b1;
    case (OPB_ADDR)
      A_CNTRL:    rd_data[2:0]            = {invert, fade_en, en};
      A_PRESCALE: rd_data[PRE_WIDTH-1:0]  = prescale;
      A_DUTY:     rd_data[PWM_BITS-1:0]   = duty;
      A_STEP:     rd_data[PWM_BITS-1:0]   = step;
      A_STATUS: begin
        rd_data[NCH-1:0] = led_out_p1;
        rd_data[16]      = busy;
      end
      A_CHSEL:    rd_data[3:0]            = chsel;
      A_LEVEL:    rd_data[PWM_BITS-1:0]   = level_sel;
      default:    rd_hit                  = 1'b0;
    endcase
  end

  assign OPB_DO = (OPB_RE && rd_hit) ? rd_data : 32'bz;

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Bench for led_pwm_dimmer: randomized duty/fade scenarios scored against
// brightness rules computed directly in plain arithmetic.
module tb_led_pwm_dimmer;

  localparam int NCH = 15;
  localparam logic [2:0] A_CNTRL = 3'd0, A_PRESCALE = 3'd1, A_DUTY = 3'd2, A_STEP = 3'd3,
                         A_STATUS = 3'd4, A_CHSEL = 3'd5, A_LEVEL = 3'd6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [31:0]    di = '0;
  wire  [31:0]    do_w;
  logic [2:0]     addr = '0;
  logic           re = 1'b0;
  logic           we = 1'b0;
  logic [NCH-1:0] led_in = '0;
  wire  [NCH-1:0] led_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_pwm_dimmer #(.NCH(NCH), .PWM_BITS(8), .PRE_WIDTH(16)) dut (
    .OPB_CLK(clk), .OPB_RST_N(rst_n), .OPB_DI(di), .OPB_DO(do_w), .OPB_ADDR(addr),
    .OPB_RE(re), .OPB_WE(we), .LED_IN(led_in), .LED_OUT(led_out)
  );

  task automatic clks(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    addr = a; di = d; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    addr = a; re = 1'b1;
    #1;
    d = do_w;
    re = 1'b0;
  endtask

  // Brightness after one period of fading: step toward target, clamp at it.
  function automatic int fade_next(input int lvl, input int tgt, input int stp);
    if (lvl < tgt) return (lvl + stp > tgt) ? tgt : lvl + stp;
    if (lvl > tgt) return (lvl - stp < tgt) ? tgt : lvl - stp;
    return lvl;
  endfunction

  task automatic test_reset();
    logic [2:0]  ra [5];
    int          rv [5];
    logic [31:0] r;
    ra = '{A_CNTRL, A_PRESCALE, A_DUTY, A_STEP, A_CHSEL};
    rv = '{1, 124, 128, 8, 0};
    rst_n = 1'b0;
    clks(2);
    rst_n = 1'b1;
    checks++;
    if (led_out !== 15'h0) begin errors++; $display("FAIL reset_led_out got %h want 0", led_out); end
    for (int i = 0; i < 5; i++) begin
      rd(ra[i], r);
      checks++;
      if (r !== 32'(rv[i])) begin errors++; $display("FAIL reset_reg%0d got %h want %h", ra[i], r, rv[i]); end
    end
    rd(A_STATUS, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL reset_status got %h want 0", r); end
    rd(A_LEVEL, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL reset_level got %h want 0", r); end
    wr(A_STATUS, 32'hFFFF_FFFF);
    wr(A_LEVEL, 32'hFFFF_FFFF);
    wr(3'd7, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      rd(ra[i], r);
      checks++;
      if (r !== 32'(rv[i])) begin errors++; $display("FAIL ro_write_reg%0d got %h want %h", ra[i], r, rv[i]); end
    end
  endtask

  // Over one full PWM period each channel is high for level*(PRESCALE+1) clocks.
  task automatic test_duty();
    int             p, d, win;
    logic [NCH-1:0] mask;
    int             cnt [NCH];
    wr(A_CNTRL, 32'h1);
    for (int k = 0; k < 6; k++) begin
      p    = (k < 3) ? 0 : int'($urandom_range(0, 2));
      d    = (k == 0) ? 'h40 : (k == 1) ? 'hFF : (k == 2) ? 0 : int'($urandom_range(1, 254));
      mask = (k < 3) ? 15'h1 : 15'($urandom);
      win  = 255 * (p + 1);
      wr(A_PRESCALE, 32'(p));
      wr(A_DUTY, 32'(d));
      led_in = mask;
      clks(2 * win + 20);
      for (int i = 0; i < NCH; i++) cnt[i] = 0;
      for (int c = 0; c < win; c++) begin
        for (int i = 0; i < NCH; i++) if (led_out[i]) cnt[i]++;
        clks(1);
      end
      for (int i = 0; i < NCH; i++) begin
        checks++;
        if (cnt[i] != (mask[i] ? d * (p + 1) : 0)) begin
          errors++;
          $display("FAIL duty_ch%0d p=%0d d=%0d high %0d want %0d", i, p, d, cnt[i], mask[i] ? d * (p + 1) : 0);
        end
      end
    end
  endtask

  task automatic follow_fade(input int start, input int tgt, input int stp);
    int          lvl, n;
    logic [31:0] r, s;
    lvl = start;
    n = 0;
    rd(A_LEVEL, r);
    while (int'(r) == lvl && n < 600) begin clks(1); rd(A_LEVEL, r); n++; end
    checks++;
    if (n >= 600) begin errors++; $display("FAIL fade_start level %0d never left %0d", r, lvl); return; end
    clks(128);
    lvl = fade_next(lvl, tgt, stp);
    for (int k = 0; k < 300; k++) begin
      rd(A_LEVEL, r);
      rd(A_STATUS, s);
      checks++;
      if (r !== 32'(lvl)) begin errors++; $display("FAIL fade_level got %0d want %0d", r, lvl); end
      checks++;
      if (s[16] !== (lvl != tgt)) begin errors++; $display("FAIL fade_busy got %b want %b", s[16], lvl != tgt); end
      if (lvl == tgt) break;
      lvl = fade_next(lvl, tgt, stp);
      clks(255);
    end
    clks(255);
    rd(A_LEVEL, r);
    rd(A_STATUS, s);
    checks++;
    if (r !== 32'(tgt) || s[16] !== 1'b0) begin
      errors++; $display("FAIL fade_settled level %0d busy %b want %0d busy 0", r, s[16], tgt);
    end
  endtask

  task automatic test_fade();
    int          ch [3], st [3], du [3];
    logic [31:0] r, s;
    ch = '{3, 3, int'($urandom_range(0, NCH - 1))};
    st = '{'h10, 'h30, int'($urandom_range(8, 255))};
    du = '{'h80, 'h80, int'($urandom_range(1, 255))};
    wr(A_PRESCALE, 32'h0);
    wr(A_CNTRL, 32'h1);
    led_in = '0;
    clks(600);
    for (int k = 0; k < 3; k++) begin
      wr(A_STEP, 32'(st[k]));
      wr(A_DUTY, 32'(du[k]));
      wr(A_CHSEL, 32'(ch[k]));
      wr(A_CNTRL, 32'h3);
      led_in[ch[k]] = 1'b1;
      follow_fade(0, du[k], st[k]);
      led_in[ch[k]] = 1'b0;
      follow_fade(du[k], 0, st[k]);
    end
    wr(A_STEP, 32'h0);
    wr(A_CHSEL, 32'h3);
    led_in[3] = 1'b1;
    clks(600);
    rd(A_LEVEL, r);
    rd(A_STATUS, s);
    checks++;
    if (r !== 32'h0 || s[16] !== 1'b1) begin
      errors++; $display("FAIL step0_freeze level %0d busy %b want 0 busy 1", r, s[16]);
    end
    wr(A_CNTRL, 32'h1);
    wr(A_DUTY, 32'h80);
    led_in = '1;
    clks(600);
    wr(A_CHSEL, 32'd15);
    rd(A_LEVEL, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL chsel15 got %h want 0", r); end
    wr(A_CHSEL, 32'd14);
    rd(A_LEVEL, r);
    checks++;
    if (r !== 32'h80) begin errors++; $display("FAIL chsel14 got %h want 80", r); end
  endtask

  task automatic test_invert_enable();
    int          d, n, lo0, hi_rest;
    logic [31:0] r;
    d = int'($urandom_range(1, 254));
    wr(A_PRESCALE, 32'h0);
    wr(A_DUTY, 32'(d));
    wr(A_CHSEL, 32'h0);
    led_in = 15'h1;
    wr(A_CNTRL, 32'h4);
    clks(5);
    checks++;
    if (led_out !== 15'h7FFF) begin errors++; $display("FAIL disabled_led_out got %h want 7fff", led_out); end
    rd(A_LEVEL, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL disabled_level got %h want 0", r); end
    rd(A_STATUS, r);
    checks++;
    if (r[14:0] !== 15'h7FFF) begin errors++; $display("FAIL disabled_status got %h want 7fff", r[14:0]); end
    wr(A_CNTRL, 32'h5);
    n = 0;
    while (led_out[0] !== 1'b0 && n < 400) begin clks(1); n++; end
    checks++;
    if (n != 256) begin errors++; $display("FAIL restart_first_on after %0d clocks want 256", n); end
    clks(10);
    lo0 = 0; hi_rest = 0;
    for (int c = 0; c < 255; c++) begin
      if (!led_out[0]) lo0++;
      if (led_out[14:1] == 14'h3FFF) hi_rest++;
      clks(1);
    end
    checks++;
    if (lo0 != d) begin errors++; $display("FAIL invert_ch0 low %0d want %0d", lo0, d); end
    checks++;
    if (hi_rest != 255) begin errors++; $display("FAIL invert_idle high %0d want 255", hi_rest); end
  endtask

  // With level 2 the output falls on the tick that moves pwm_cnt 1 -> 2.
  task automatic test_prescale_tick();
    logic prev;
    int   n;
    wr(A_CNTRL, 32'h1);
    wr(A_DUTY, 32'h2);
    led_in = 15'h1;
    wr(A_PRESCALE, 32'd5);
    clks(2 * 1530 + 20);
    prev = led_out[0];
    n = 0;
    while (n < 3200) begin
      clks(1);
      n++;
      if (!prev && led_out[0]) break;
      prev = led_out[0];
    end
    checks++;
    if (n >= 3200) begin errors++; $display("FAIL prescale_rise not seen in %0d clocks", n); return; end
    clks(4);
    wr(A_PRESCALE, 32'd3);
    n = 0;
    while (led_out[0] === 1'b1 && n < 50) begin clks(1); n++; end
    checks++;
    if (n != 5) begin errors++; $display("FAIL prescale_write_tick fall after %0d clocks want 5", n); end
  endtask

  task automatic test_reset_mid_fade();
    logic [2:0]  ra [5];
    int          rv [5];
    logic [31:0] r, s;
    ra = '{A_CNTRL, A_PRESCALE, A_DUTY, A_STEP, A_CHSEL};
    rv = '{1, 124, 128, 8, 0};
    wr(A_PRESCALE, 32'h0);
    wr(A_STEP, 32'h1);
    wr(A_DUTY, 32'hFF);
    wr(A_CHSEL, 32'h0);
    wr(A_CNTRL, 32'h3);
    led_in = '1;
    clks(2000);
    rd(A_LEVEL, r);
    rd(A_STATUS, s);
    checks++;
    if (r == 32'h0 || r >= 32'hFF || s[16] !== 1'b1) begin
      errors++; $display("FAIL midfade level %0d busy %b want 1..254 busy 1", r, s[16]);
    end
    rst_n = 1'b0;
    clks(1);
    rst_n = 1'b1;
    checks++;
    if (led_out !== 15'h0) begin errors++; $display("FAIL rst_pulse_led_out got %h want 0", led_out); end
    rd(A_LEVEL, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL rst_pulse_level got %h want 0", r); end
    for (int i = 0; i < 5; i++) begin
      rd(ra[i], r);
      checks++;
      if (r !== 32'(rv[i])) begin errors++; $display("FAIL rst_pulse_reg%0d got %h want %h", ra[i], r, rv[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_duty();
    test_fade();
    test_invert_enable();
    test_prescale_tick();
    test_reset_mid_fade();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
